// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with prioritised redirects, halt FSM and a circular return-address stack.
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter int NREDIR = 2,
  parameter int RAS_DEPTH = 4,
  parameter int INC = 4,
  parameter int ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    en,
  input  logic                    halt,
  input  logic [NREDIR-1:0]       redir_valid,
  input  logic [NREDIR*WIDTH-1:0] redir_pc,
  input  logic                    call,
  input  logic                    ret,
  output logic [WIDTH-1:0]        pc,
  output logic                    halted,
  output logic                    ras_empty,
  output logic                    ras_full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] AMASK = {WIDTH{1'b1}} << ALIGN_BITS;
  typedef enum logic {RUN, HALTED} state_t;
  state_t state;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr, top, ras_wa;
  logic [PW:0] cnt;
  logic redir_any, adv, pop, ras_we;
  logic [WIDTH-1:0] redir_tgt, seq_pc;
  // Scan high to low so the lowest set channel wins.
  always_comb begin
    redir_any = 1'b0;
    redir_tgt = '0;
    for (int i = NREDIR - 1; i >= 0; i--)
      if (redir_valid[i]) begin
        redir_any = 1'b1;
        redir_tgt = redir_pc[i*WIDTH +: WIDTH];
      end
  end
  assign seq_pc = (pc + WIDTH'(INC)) & AMASK;
  assign top = ptr - PW'(1);
  assign adv = state == RUN && !redir_any && en && !halt;
  assign pop = adv && ret && !ras_empty;
  assign ras_we = adv && call;
  assign ras_wa = pop ? top : ptr;
  assign halted = state == HALTED;
  assign ras_empty = cnt == '0;
  assign ras_full = cnt == (PW+1)'(RAS_DEPTH);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc <= RESET_PC & AMASK;
      state <= RUN;
      ptr <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      if (redir_any) pc <= redir_tgt & AMASK;
      else if (en && halt) state <= HALTED;
      else if (en) begin
        pc <= pop ? ras[top] & AMASK : seq_pc;
        if (call && !pop) begin
          ptr <= ptr + PW'(1);
          cnt <= ras_full ? cnt : cnt + 1'b1;
        end else if (pop && !call) begin
          ptr <= top;
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
  // Contents need no reset; a simultaneous call+ret replaces the popped top in place.
  always_ff @(posedge CLK)
    if (ras_we) ras[ras_wa] <= seq_pc;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  logic en = 1'b0, halt = 1'b0, call = 1'b0, ret = 1'b0;
  logic [1:0] redir_valid = '0;
  logic [63:0] redir_pc = '0;
  logic [31:0] pc;
  logic halted, ras_empty, ras_full;
  int checks = 0, failures = 0;

  pc_sequencer #(.RESET_PC(32'h100)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .halt(halt), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .call(call), .ret(ret), .pc(pc), .halted(halted),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic jump(input logic [31:0] a);
    redir_valid = 2'b01;
    redir_pc[31:0] = a;
    step();
    redir_valid = 2'b00;
  endtask

  initial begin
    #2 nRST = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h100);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_empty", 32'(ras_empty), 1);
    chk("rst_full", 32'(ras_full), 0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    en = 1'b1;
    chk("seq0", pc, 32'h100);
    step(); chk("seq1", pc, 32'h104);
    step(); chk("seq2", pc, 32'h108);
    step(); chk("seq3", pc, 32'h10C);
    #2 nRST = 1'b0;
    #1 chk("async_rst", pc, 32'h100);
    @(posedge CLK);
    #1 nRST = 1'b1;
    en = 1'b0;
    redir_valid = 2'b11;
    redir_pc = {32'h3000, 32'h2000};
    step(); chk("redir_prio", pc, 32'h2000);
    redir_valid = 2'b10;
    redir_pc[63:32] = 32'h3003;
    step(); chk("redir_align", pc, 32'h3000);
    redir_valid = 2'b00;
    jump(32'h40);
    en = 1'b1; call = 1'b1;
    step(); chk("call_pc", pc, 32'h44); chk("call_nonempty", 32'(ras_empty), 0);
    call = 1'b0; ret = 1'b1;
    jump(32'h800);
    chk("redir_over_ret", pc, 32'h800);
    chk("redir_no_pop", 32'(ras_empty), 0);
    step(); chk("ret_pc", pc, 32'h44); chk("ret_empty", 32'(ras_empty), 1);
    step(); chk("ret_empty_seq", pc, 32'h48);
    ret = 1'b0;
    jump(32'h0);
    call = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("ovf_pc", pc, 32'h14);
    chk("ovf_full", 32'(ras_full), 1);
    call = 1'b0; ret = 1'b1;
    step(); chk("pop1", pc, 32'h14);
    chk("pop1_notfull", 32'(ras_full), 0);
    step(); chk("pop2", pc, 32'h10);
    step(); chk("pop3", pc, 32'hC);
    step(); chk("pop4", pc, 32'h8);
    chk("pop_empty", 32'(ras_empty), 1);
    ret = 1'b0;
    jump(32'h200);
    call = 1'b1;
    step(); chk("cr_push", pc, 32'h204);
    ret = 1'b1;
    step(); chk("cr_pc", pc, 32'h204); chk("cr_nonempty", 32'(ras_empty), 0);
    call = 1'b0;
    step(); chk("cr_replaced", pc, 32'h208); chk("cr_empty", 32'(ras_empty), 1);
    ret = 1'b0;
    jump(32'hFFFFFFFC);
    en = 1'b0; call = 1'b1;
    step(); step();
    chk("stall_pc", pc, 32'hFFFFFFFC);
    chk("stall_nocall", 32'(ras_empty), 1);
    en = 1'b1; call = 1'b0;
    step(); chk("wrap", pc, 32'h0);
    jump(32'h20);
    halt = 1'b1; call = 1'b1;
    step();
    chk("halt_flag", 32'(halted), 1);
    chk("halt_pc", pc, 32'h20);
    chk("halt_nopush", 32'(ras_empty), 1);
    halt = 1'b0;
    jump(32'h900);
    step();
    chk("halted_pc", pc, 32'h20);
    chk("halted_empty", 32'(ras_empty), 1);
    chk("halted_stays", 32'(halted), 1);
    call = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("unhalt", 32'(halted), 0);
    chk("unhalt_pc", pc, 32'h100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised fetch-stage program counter; successor to the single-width enable/next-count PC.
- Adds a reset vector, N prioritised redirect channels for branch resolve, exceptions and flush, a halt state machine, and a circular return-address stack (RAS) for call/return prediction.
- Sits between the hazard/control unit and instruction fetch. Drives the instruction memory address every cycle.

Parameters:
- WIDTH, 32, PC and address width in bits.
- NREDIR, 2, number of redirect channels; index 0 has highest priority.
- RAS_DEPTH, 4, RAS entries; must be a power of two and at least 2.
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low PC bits forced to zero.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; asynchronous, active-low.
- en  in  1  advance the PC; 0 means stall.
- halt  in  1  halt request from decode.
- redir_valid  in  NREDIR  per-channel redirect request.
- redir_pc  in  NREDIR*WIDTH  redirect targets; channel i occupies bits [i*WIDTH +: WIDTH].
- call  in  1  fetched instruction is a call; push the return address.
- ret  in  1  fetched instruction is a return; pop and predict.
- pc  out  WIDTH  current PC (registered).
- halted  out  1  state is HALTED.
- ras_empty  out  1  RAS count is 0.
- ras_full  out  1  RAS count is RAS_DEPTH.

Behaviour:
- Reset (async, nRST=0):
  - pc=RESET_PC with low ALIGN_BITS cleared.
  - State RUN; halted=0.
  - RAS pointer=0, count=0, so ras_empty=1 and ras_full=0.
  - RAS contents are don't-care.
- Reset applies immediately mid-operation and overrides every other input.
- FSM has two states, RUN and HALTED.
  - RUN -> HALTED when en=1, halt=1 and no redirect_valid bit is set. The PC holds its value on that edge.
  - HALTED is terminal; only reset leaves it. In HALTED all inputs are ignored and pc, RAS and flags are frozen.
- Next-PC selection in RUN, applied on the rising edge, in this priority order:
  1. Any redir_valid bit set: the lowest set index wins. pc <= redir_pc[i]. This applies even when en=0 (flush overrides stall). call and ret are ignored that cycle.
  2. en=0: pc holds; call and ret are ignored.
  3. en=1 and ret=1 with the RAS non-empty: pc <= the top RAS entry, and the entry is popped.
  4. en=1 otherwise: pc <= pc+INC, with modulo 2^WIDTH wrap-around (all-ones region + INC wraps to 0).
- Every value loaded into pc has its low ALIGN_BITS forced to zero.
- RAS operations (only when en=1, no redirect, state RUN):
  - call pushes pc+INC (wrapped, aligned) at the pointer; pointer increments mod RAS_DEPTH; count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry (circular buffer). ras_full stays 1.
  - ret with count 0: no pop; PC takes the sequential path.
  - call and ret in the same cycle (nonempty): the PC takes the popped target, and the top entry is replaced by pc+INC, so count is unchanged. With an empty RAS, call+ret pushes and the PC goes sequential.
  - call and halt in the same cycle: the halt takes effect and the push is suppressed.
- Latency: one cycle from input to new pc. Flags are registered and reflect state after the edge.

Test Plan:
- Reset/sequential: RESET_PC=32'h100, release reset, en=1 for 3 cycles -> pc 0x100, 0x104, 0x108, 0x10C. Assert nRST low mid-run -> pc is 0x100 asynchronously.
- Redirect priority: redir_valid=2'b11 with targets 0x2000 (ch0) and 0x3000 (ch1), en=0 -> next pc 0x2000. Target 0x3003 on ch1 alone -> pc 0x3000.
- RAS round-trip: pc=0x40 with call=1 -> ras_empty=0. Redirect to 0x800, then ret=1 with en=1 -> pc 0x44 and ras_empty=1. A second ret -> pc 0x48 (sequential).
- RAS overflow (depth 4): calls at pc 0x0, 0x4, 0x8, 0xC, 0x10 -> ras_full=1. Four rets return 0x14, 0x10, 0xC, 0x8, then ras_empty=1.
- Stall/wrap: pc=32'hFFFFFFFC, en=0 for 2 cycles -> held, with call ignored (ras_empty stays 1). Then en=1 -> pc 0x0.
- Halt: halt=1 with en=1 at pc 0x20 -> halted=1 and pc stays 0x20. Subsequent redirects, en and call have no effect. Reset clears halted.
